ysyx_22040729_operand_issue: RTL and testbench

Operand-fetch/issue stage between instruction decode and execute. Accepts one decoded instruction per cycle, drives the register file's synchronous read ports, and tracks pending destination registers in a per-register scoreboard. Corrects the register file's one-cycle read-after-write staleness with a registered writeback bypass, and issues instructions with resolved 64-bit operands to execute over a valid/ready handshake.

---
 rtl/ysyx_22040729_operand_issue.sv | 156 +++++++++++++++
 tb/tb_ysyx_22040729_operand_issue.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040729_operand_issue.sv
// Operand fetch/issue stage: holds one decoded instruction, reads the register file,
// stalls on scoreboard hazards and resolves operands through a registered writeback bypass.
module ysyx_22040729_operand_issue #(
  parameter int REGI_DEPTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64,
  localparam int AW        = $clog2(REGI_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [AW-1:0]         in_rs1,
  input  logic [AW-1:0]         in_rs2,
  input  logic                  in_use_rs1,
  input  logic                  in_use_rs2,
  input  logic [AW-1:0]         in_rd,
  input  logic                  in_rd_wen,
  output logic [AW-1:0]         rf_raddr1,
  output logic [AW-1:0]         rf_raddr2,
  input  logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [DATA_WIDTH-1:0] rf_rdata2,
  input  logic                  wb_valid,
  input  logic [AW-1:0]         wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [AW-1:0]         out_rd,
  output logic                  out_rd_wen,
  output logic [DATA_WIDTH-1:0] out_src1,
  output logic [DATA_WIDTH-1:0] out_src2
);

  logic                  h_valid_q, h_valid_d;
  logic [PC_WIDTH-1:0]   h_pc_q, h_pc_d;
  logic [AW-1:0]         h_rs1_q, h_rs1_d;
  logic [AW-1:0]         h_rs2_q, h_rs2_d;
  logic [AW-1:0]         h_rd_q, h_rd_d;
  logic                  h_use1_q, h_use1_d;
  logic                  h_use2_q, h_use2_d;
  logic                  h_rd_wen_q, h_rd_wen_d;
  logic [REGI_DEPTH-1:0] sb_q, sb_d;
  logic                  bp_valid_q, bp_valid_d;
  logic [AW-1:0]         bp_rd_q, bp_rd_d;
  logic [DATA_WIDTH-1:0] bp_data_q, bp_data_d;
  logic                  hazard;
  logic                  out_fire;
  logic                  accept;

  // Handshake: the read port follows the incoming instruction on accept, otherwise
  // keeps re-reading the held sources so stale data refreshes every stall cycle.
  always_comb begin
    hazard    = (h_use1_q && sb_q[h_rs1_q]) ||
                (h_use2_q && sb_q[h_rs2_q]) ||
                (h_rd_wen_q && sb_q[h_rd_q]);
    out_valid = h_valid_q && !hazard && !flush;
    out_fire  = out_valid && out_ready;
    in_ready  = !h_valid_q || out_fire;
    accept    = in_valid && in_ready;
    rf_raddr1 = accept ? in_rs1 : h_rs1_q;
    rf_raddr2 = accept ? in_rs2 : h_rs2_q;
  end

  assign out_pc     = h_pc_q;
  assign out_rd     = h_rd_q;
  assign out_rd_wen = h_rd_wen_q;

  always_comb begin
    out_src1 = rf_rdata1;
    if (h_rs1_q == '0) begin
      out_src1 = '0;
    end else if (bp_valid_q && (bp_rd_q == h_rs1_q)) begin
      out_src1 = bp_data_q;
    end
  end

  always_comb begin
    out_src2 = rf_rdata2;
    if (h_rs2_q == '0) begin
      out_src2 = '0;
    end else if (bp_valid_q && (bp_rd_q == h_rs2_q)) begin
      out_src2 = bp_data_q;
    end
  end

  always_comb begin
    h_valid_d  = h_valid_q;
    h_pc_d     = h_pc_q;
    h_rs1_d    = h_rs1_q;
    h_rs2_d    = h_rs2_q;
    h_rd_d     = h_rd_q;
    h_use1_d   = h_use1_q;
    h_use2_d   = h_use2_q;
    h_rd_wen_d = h_rd_wen_q;
    if (accept) begin
      h_valid_d  = 1'b1;
      h_pc_d     = in_pc;
      h_rs1_d    = in_rs1;
      h_rs2_d    = in_rs2;
      h_rd_d     = in_rd;
      h_use1_d   = in_use_rs1;
      h_use2_d   = in_use_rs2;
      h_rd_wen_d = in_rd_wen;
    end else if (out_fire || flush) begin
      h_valid_d = 1'b0;
    end

    // Set after clear so an issue to the same index being retired stays pending.
    sb_d = sb_q;
    if (wb_valid) begin
      sb_d[wb_rd] = 1'b0;
    end
    if (out_fire && h_rd_wen_q && (h_rd_q != '0)) begin
      sb_d[h_rd_q] = 1'b1;
    end
    sb_d[0] = 1'b0;

    bp_valid_d = wb_valid && (wb_rd != '0);
    bp_rd_d    = wb_rd;
    bp_data_d  = wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_valid_q  <= 1'b0;
      h_pc_q     <= '0;
      h_rs1_q    <= '0;
      h_rs2_q    <= '0;
      h_rd_q     <= '0;
      h_use1_q   <= 1'b0;
      h_use2_q   <= 1'b0;
      h_rd_wen_q <= 1'b0;
      sb_q       <= '0;
      bp_valid_q <= 1'b0;
      bp_rd_q    <= '0;
      bp_data_q  <= '0;
    end else begin
      h_valid_q  <= h_valid_d;
      h_pc_q     <= h_pc_d;
      h_rs1_q    <= h_rs1_d;
      h_rs2_q    <= h_rs2_d;
      h_rd_q     <= h_rd_d;
      h_use1_q   <= h_use1_d;
      h_use2_q   <= h_use2_d;
      h_rd_wen_q <= h_rd_wen_d;
      sb_q       <= sb_d;
      bp_valid_q <= bp_valid_d;
      bp_rd_q    <= bp_rd_d;
      bp_data_q  <= bp_data_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040729_operand_issue.sv
// Self-checking bench for the operand issue stage: directed scenarios plus a randomized
// run against an architectural-register / pending-write reference model.
module tb_ysyx_22040729_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_use_rs1, in_use_rs2, in_rd_wen;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [63:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [63:0] out_src1, out_src2;

  int checks = 0;
  int errors = 0;

  logic [63:0] rf_mem [32];
  logic [63:0] golden [32];

  int          pend_rd [$];
  int          pend_t [$];
  logic        m_held;
  logic [63:0] m_pc;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic        m_u1, m_u2, m_wen;

  ysyx_22040729_operand_issue dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_src1(out_src1), .out_src2(out_src2)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file with read-before-write; x0 deliberately stores junk.
  always @(posedge clk) begin
    rf_rdata1 <= rf_mem[rf_raddr1];
    rf_rdata2 <= rf_mem[rf_raddr2];
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 64'(i) * 64'h11;
    end else if (wb_valid) begin
      rf_mem[wb_rd] <= wb_data;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) golden[i] <= (i == 0) ? 64'h0 : 64'(i) * 64'h11;
    end else if (wb_valid && (wb_rd != 5'd0)) begin
      golden[wb_rd] <= wb_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] pc, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic wen);
    in_valid   = 1'b1;
    in_pc      = pc;
    in_rs1     = rs1;
    in_use_rs1 = u1;
    in_rs2     = rs2;
    in_use_rs2 = u2;
    in_rd      = rd;
    in_rd_wen  = wen;
  endtask

  task automatic idle_inputs;
    in_valid   = 1'b0;
    in_pc      = 64'h0;
    in_rs1     = 5'd0;
    in_rs2     = 5'd0;
    in_use_rs1 = 1'b0;
    in_use_rs2 = 1'b0;
    in_rd      = 5'd0;
    in_rd_wen  = 1'b0;
    wb_valid   = 1'b0;
    wb_rd      = 5'd0;
    wb_data    = 64'h0;
    flush      = 1'b0;
    out_ready  = 1'b1;
  endtask

  task automatic do_reset;
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_pc !== 64'h0) begin errors++; $display("[TB] FAIL reset_out_pc got %h exp 0", out_pc); end
    checks++; if (out_rd !== 5'd0 || out_rd_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_rd got %0d/%b exp 0/0", out_rd, out_rd_wen); end
    checks++; if (out_src1 !== 64'h0 || out_src2 !== 64'h0) begin errors++; $display("[TB] FAIL reset_out_src got %h %h exp 0 0", out_src1, out_src2); end
    checks++; if (rf_raddr1 !== 5'd0 || rf_raddr2 !== 5'd0) begin errors++; $display("[TB] FAIL reset_raddr got %0d %0d exp 0 0", rf_raddr1, rf_raddr2); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [63:0] pcs [4];
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i < 4) begin
        pcs[i] = 64'h1000 + 64'(4 * i);
        applyStimulus(pcs[i], 5'(i + 1), 1'b1, 5'(i + 1), 1'b1, 5'd0, 1'b0);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 4) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d] got %b exp 1", i, in_ready); end
        checks++; if (rf_raddr1 !== 5'(i + 1)) begin errors++; $display("[TB] FAIL b2b_raddr1[%0d] got %0d exp %0d", i, rf_raddr1, i + 1); end
      end
      if (i >= 1 && i <= 4) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d] got %b exp 1", i, out_valid); end
        checks++; if (out_pc !== pcs[i-1]) begin errors++; $display("[TB] FAIL b2b_pc[%0d] got %h exp %h", i, out_pc, pcs[i-1]); end
        checks++; if (out_src1 !== 64'(i) * 64'h11) begin errors++; $display("[TB] FAIL b2b_src1[%0d] got %h exp %h", i, out_src1, 64'(i) * 64'h11); end
        checks++; if (out_src2 !== 64'(i) * 64'h11) begin errors++; $display("[TB] FAIL b2b_src2[%0d] got %h exp %h", i, out_src2, 64'(i) * 64'h11); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle[%0d] got %b exp 0", i, out_valid); end
      end
    end
  endtask

  task automatic test_raw;
    do_reset();
    tick(); applyStimulus(64'h2000, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL raw_accept_a got %b exp 1", in_ready); end
    tick(); applyStimulus(64'h2004, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd5) begin errors++; $display("[TB] FAIL raw_issue_a got %b/%0d exp 1/5", out_valid, out_rd); end
    for (int k = 0; k < 3; k++) begin
      tick(); in_valid = 1'b0;
      if (k == 2) begin wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD_BEEF; end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL raw_stall[%0d] got %b exp 0", k, out_valid); end
    end
    tick(); wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h2004) begin errors++; $display("[TB] FAIL raw_issue_b got %b/%h exp 1/2004", out_valid, out_pc); end
    checks++; if (out_src1 !== 64'hDEAD_BEEF) begin errors++; $display("[TB] FAIL raw_bypass got %h exp deadbeef", out_src1); end
    tick();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL raw_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_x0;
    do_reset();
    tick(); applyStimulus(64'h100, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF; out_ready = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_accept got %b exp 1", in_ready); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL x0_no_stall got %b exp 1", out_valid); end
    checks++; if (out_src1 !== 64'h0 || out_src2 !== 64'h0) begin errors++; $display("[TB] FAIL x0_src_bp got %h %h exp 0 0", out_src1, out_src2); end
    tick(); wb_valid = 1'b0; out_ready = 1'b1;
    applyStimulus(64'h104, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1);
    @(negedge clk);
    checks++; if (out_src1 !== 64'h0 || out_src2 !== 64'h0) begin errors++; $display("[TB] FAIL x0_src_rf got %h %h exp 0 0", out_src1, out_src2); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL x0_ready got %b exp 1", in_ready); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h104) begin errors++; $display("[TB] FAIL x0_sb0_clear got %b/%h exp 1/104", out_valid, out_pc); end
  endtask

  task automatic test_backpressure;
    do_reset();
    tick(); applyStimulus(64'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    tick(); applyStimulus(64'h304, 5'd1, 1'b1, 5'd6, 1'b1, 5'd9, 1'b0);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h300) begin errors++; $display("[TB] FAIL bp_issue_a got %b/%h exp 1/300", out_valid, out_pc); end
    for (int k = 0; k < 5; k++) begin
      tick(); out_ready = 1'b0;
      applyStimulus(64'h308, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
      wb_valid = (k == 1); wb_rd = 5'd6; wb_data = 64'hCAFE;
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d] got %b exp 0", k, in_ready); end
      checks++; if (out_pc !== 64'h304 || out_rd !== 5'd9 || out_rd_wen !== 1'b0) begin errors++; $display("[TB] FAIL bp_stable[%0d] got %h/%0d/%b exp 304/9/0", k, out_pc, out_rd, out_rd_wen); end
      checks++; if (out_src1 !== 64'h11) begin errors++; $display("[TB] FAIL bp_src1[%0d] got %h exp 11", k, out_src1); end
      checks++; if (out_valid !== (k >= 2)) begin errors++; $display("[TB] FAIL bp_valid[%0d] got %b exp %b", k, out_valid, k >= 2); end
      if (k >= 2) begin
        checks++; if (out_src2 !== 64'hCAFE) begin errors++; $display("[TB] FAIL bp_src2[%0d] got %h exp cafe", k, out_src2); end
      end
    end
    tick(); out_ready = 1'b1; wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_src2 !== 64'hCAFE || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release got %b/%h/%b exp 1/cafe/1", out_valid, out_src2, in_ready); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h308 || out_src1 !== 64'h22) begin errors++; $display("[TB] FAIL bp_next got %b/%h/%h exp 1/308/22", out_valid, out_pc, out_src1); end
  endtask

  task automatic test_waw;
    do_reset();
    tick(); applyStimulus(64'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick(); applyStimulus(64'h404, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7) begin errors++; $display("[TB] FAIL waw_issue_a got %b/%0d exp 1/7", out_valid, out_rd); end
    for (int k = 0; k < 2; k++) begin
      tick(); in_valid = 1'b0;
      if (k == 1) begin wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 64'h77; end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL waw_stall[%0d] got %b exp 0", k, out_valid); end
    end
    tick(); wb_valid = 1'b0; applyStimulus(64'h408, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h404 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL waw_issue_b got %b/%h/%b exp 1/404/1", out_valid, out_pc, in_ready); end
    tick(); applyStimulus(64'h40C, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 64'h88;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd8) begin errors++; $display("[TB] FAIL waw_issue_c got %b/%0d exp 1/8", out_valid, out_rd); end
    for (int k = 0; k < 3; k++) begin
      tick(); in_valid = 1'b0;
      wb_valid = (k == 2); wb_rd = 5'd8; wb_data = 64'h888;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL waw_set_priority[%0d] got %b exp 0", k, out_valid); end
    end
    tick(); wb_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_pc !== 64'h40C || out_src1 !== 64'h888) begin errors++; $display("[TB] FAIL waw_issue_e got %b/%h/%h exp 1/40c/888", out_valid, out_pc, out_src1); end
  endtask

  task automatic test_flush_reset;
    do_reset();
    tick(); applyStimulus(64'h500, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    tick(); applyStimulus(64'h504, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_prestall got %b exp 0", out_valid); end
    tick(); flush = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_cycle got %b/%b exp 0/0", out_valid, in_ready); end
    tick(); flush = 1'b0; applyStimulus(64'h508, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_dropped got %b/%b exp 1/0", in_ready, out_valid); end
    tick(); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_pc !== 64'h508) begin errors++; $display("[TB] FAIL flush_sb_kept got %b/%h exp 0/508", out_valid, out_pc); end
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_hs got %b/%b exp 0/1", out_valid, in_ready); end
    checks++; if (out_pc !== 64'h0 || out_src1 !== 64'h0 || rf_raddr1 !== 5'd0) begin errors++; $display("[TB] FAIL midreset_vals got %h/%h/%0d exp 0/0/0", out_pc, out_src1, rf_raddr1); end
    tick(); applyStimulus(64'h50C, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_src1 !== 64'h33) begin errors++; $display("[TB] FAIL midreset_sb_clear got %b/%h exp 1/33", out_valid, out_src1); end
  endtask

  // Reference: an instruction may issue exactly when none of its used sources or its
  // destination has an outstanding write; its operands are the architectural values.
  task automatic test_random;
    logic        hz, fire, held_before, wb_now;
    logic [63:0] exp1, exp2;
    do_reset();
    pend_rd.delete();
    pend_t.delete();
    m_held = 1'b0;
    for (int cyc = 0; cyc < 1540; cyc++) begin
      tick();
      if (cyc < 1500 && $urandom_range(0, 3) != 0) begin
        applyStimulus({$urandom, $urandom}, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = (cyc >= 1500) || ($urandom_range(0, 3) != 0);
      wb_now = (pend_rd.size() > 0) && (pend_t[0] <= cyc);
      if (wb_now) begin
        wb_valid = 1'b1; wb_rd = 5'(pend_rd[0]); wb_data = {$urandom, $urandom};
      end else if ($urandom_range(0, 7) == 0) begin
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = {$urandom, $urandom};
      end else begin
        wb_valid = 1'b0;
      end
      @(negedge clk);
      hz = 1'b0;
      foreach (pend_rd[j]) begin
        if ((m_u1 && m_rs1 == 5'(pend_rd[j])) || (m_u2 && m_rs2 == 5'(pend_rd[j])) ||
            (m_wen && m_rd == 5'(pend_rd[j]))) hz = 1'b1;
      end
      held_before = m_held;
      fire = m_held && !hz && out_ready;
      checks++; if (out_valid !== (m_held && !hz)) begin errors++; $display("[TB] FAIL rnd_valid@%0d got %b exp %b", cyc, out_valid, m_held && !hz); end
      checks++; if (in_ready !== (!m_held || fire)) begin errors++; $display("[TB] FAIL rnd_ready@%0d got %b exp %b", cyc, in_ready, !m_held || fire); end
      if (fire) begin
        exp1 = (m_rs1 == 5'd0) ? 64'h0 : golden[m_rs1];
        exp2 = (m_rs2 == 5'd0) ? 64'h0 : golden[m_rs2];
        checks++; if (out_pc !== m_pc || out_rd !== m_rd || out_rd_wen !== m_wen) begin errors++; $display("[TB] FAIL rnd_ctrl@%0d got %h/%0d/%b exp %h/%0d/%b", cyc, out_pc, out_rd, out_rd_wen, m_pc, m_rd, m_wen); end
        if (m_u1) begin
          checks++; if (out_src1 !== exp1) begin errors++; $display("[TB] FAIL rnd_src1@%0d x%0d got %h exp %h", cyc, m_rs1, out_src1, exp1); end
        end
        if (m_u2) begin
          checks++; if (out_src2 !== exp2) begin errors++; $display("[TB] FAIL rnd_src2@%0d x%0d got %h exp %h", cyc, m_rs2, out_src2, exp2); end
        end
        m_held = 1'b0;
      end
      if (wb_now) begin
        void'(pend_rd.pop_front());
        void'(pend_t.pop_front());
      end
      if (fire && m_wen && m_rd != 5'd0) begin
        pend_rd.push_back(int'(m_rd));
        pend_t.push_back(cyc + int'($urandom_range(1, 4)));
      end
      if (in_valid && (!held_before || fire)) begin
        m_held = 1'b1;
        m_pc = in_pc; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd;
        m_u1 = in_use_rs1; m_u2 = in_use_rs2; m_wen = in_rd_wen;
      end
    end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rnd_drain got %b/%b exp 0/1", out_valid, in_ready); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    $display("[TB] starting operand issue bench");
    test_reset();
    test_back_to_back();
    test_raw();
    test_x0();
    test_backpressure();
    test_waw();
    test_flush_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
